// File: rtl/alu_seq_driver_pkg.sv
// Shared types and default widths for the ALU sequencing driver.
// Imported by the driver interface, the driver and its bench.
package alu_drv_pkg;

    localparam int ALU_W   = 4;
    localparam int ALU_OPW = 4;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        HOLD
    } state_t;

    typedef enum logic {
        SINGLE,
        SWEEP
    } mode_t;

endpackage

// File: rtl/alu_seq_driver_if.sv
// Command, sweep, ALU-drive and response bundle of the ALU driver.
// master is the harness/ALU side, slave is the driver.
interface alu_seq_driver_if
    import alu_drv_pkg::*;
#(
    parameter int W   = ALU_W,
    parameter int OPW = ALU_OPW
);

    logic           cmd_valid;
    logic           cmd_ready;
    logic [OPW-1:0] cmd_opcode;
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;

    logic           sweep_start;
    logic [W-1:0]   sweep_a;
    logic [W-1:0]   sweep_b;

    logic [OPW-1:0] alu_opcode;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_y;
    logic           alu_v;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [OPW-1:0] rsp_opcode;
    logic [W-1:0]   rsp_y;
    logic           rsp_v;
    logic           rsp_last;

    logic [OPW:0]   v_count;
    logic           busy;

    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b,
        output sweep_start, sweep_a, sweep_b,
        output alu_y, alu_v, rsp_ready,
        input  cmd_ready, alu_opcode, alu_a, alu_b,
        input  rsp_valid, rsp_opcode, rsp_y, rsp_v,
        input  rsp_last, v_count, busy
    );

    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b,
        input  sweep_start, sweep_a, sweep_b,
        input  alu_y, alu_v, rsp_ready,
        output cmd_ready, alu_opcode, alu_a, alu_b,
        output rsp_valid, rsp_opcode, rsp_y, rsp_v,
        output rsp_last, v_count, busy
    );

endinterface

// File: rtl/alu_seq_driver.sv
// Clocked initiator for the combinational ALU: single commands or a
// full opcode sweep, each result returned over a response handshake.
module alu_seq_driver
    import alu_drv_pkg::*;
#(
    parameter int W   = ALU_W,
    parameter int OPW = ALU_OPW
) (
    input logic              clk,
    input logic              rst_n,
    alu_seq_driver_if.slave  bus
);

    state_t         state;
    state_t         state_nx;
    mode_t          mode;

    logic [OPW-1:0] op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [OPW-1:0] rsp_op_q;
    logic [W-1:0]   rsp_y_q;
    logic           rsp_v_q;
    logic           rsp_last_q;
    logic [OPW:0]   v_count_q;

    localparam logic [OPW-1:0] OP_ONE = {{(OPW-1){1'b0}}, 1'b1};
    localparam logic [OPW:0]   VC_ONE = {{OPW{1'b0}}, 1'b1};

    assign bus.cmd_ready  = (state == IDLE) && !bus.sweep_start;
    assign bus.rsp_valid  = (state == HOLD);
    assign bus.busy       = (state != IDLE);
    assign bus.alu_opcode = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.rsp_opcode = rsp_op_q;
    assign bus.rsp_y      = rsp_y_q;
    assign bus.rsp_v      = rsp_v_q;
    assign bus.rsp_last   = rsp_last_q;
    assign bus.v_count    = v_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.sweep_start || bus.cmd_valid) begin
                    state_nx = DRIVE;
                end
            end
            DRIVE: begin
                state_nx = HOLD;
            end
            HOLD: begin
                if (bus.rsp_ready) begin
                    state_nx = rsp_last_q ? IDLE : DRIVE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode       <= SINGLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rsp_op_q   <= '0;
            rsp_y_q    <= '0;
            rsp_v_q    <= 1'b0;
            rsp_last_q <= 1'b0;
            v_count_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A sweep start outranks a command in the same cycle.
                    if (bus.sweep_start) begin
                        mode      <= SWEEP;
                        op_q      <= '0;
                        a_q       <= bus.sweep_a;
                        b_q       <= bus.sweep_b;
                        v_count_q <= '0;
                    end else if (bus.cmd_valid) begin
                        mode <= SINGLE;
                        op_q <= bus.cmd_opcode;
                        a_q  <= bus.cmd_a;
                        b_q  <= bus.cmd_b;
                    end
                end
                DRIVE: begin
                    rsp_op_q   <= op_q;
                    rsp_y_q    <= bus.alu_y;
                    rsp_v_q    <= bus.alu_v;
                    rsp_last_q <= (mode == SINGLE) || (&op_q);
                    if (mode == SWEEP && bus.alu_v) begin
                        v_count_q <= v_count_q + VC_ONE;
                    end
                end
                HOLD: begin
                    // Last response never advances, so the opcode cannot wrap.
                    if (bus.rsp_ready && !rsp_last_q) begin
                        op_q <= op_q + OP_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_driver.sv
// Randomized bench for alu_seq_driver with a stub ALU and a
// transaction-level reference model of the command/sweep protocol.
module tb_alu_seq_driver;
    import alu_drv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_seq_driver_if bus ();

    alu_seq_driver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Stub ALU: y = a ^ b ^ opcode, v = opcode[0].
    assign bus.alu_y = bus.alu_a ^ bus.alu_b ^ bus.alu_opcode;
    assign bus.alu_v = bus.alu_opcode[0];

    // Reference model: one transaction in flight at most.
    bit       m_busy;
    bit       m_drive;
    bit       m_sweep;
    bit [3:0] m_op;
    bit [3:0] m_a;
    bit [3:0] m_b;
    int       m_vc;
    bit       cmd_taken;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_drive = 0;
        m_sweep = 0;
        m_op    = 0;
        m_a     = 0;
        m_b     = 0;
        m_vc    = 0;
    endtask

    // Called just after a falling edge with inputs driven; checks the
    // current cycle, then advances the model across the coming rising edge.
    task automatic tick();
        bit exp_valid;
        bit last;
        #1;
        exp_valid = m_busy && !m_drive;
        last      = !m_sweep || (m_op == 4'hF);
        chk("busy", bus.busy, m_busy);
        chk("cmd_ready", bus.cmd_ready, !m_busy && !bus.sweep_start);
        chk("rsp_valid", bus.rsp_valid, exp_valid);
        chk("alu_opcode", bus.alu_opcode, m_op);
        chk("alu_a", bus.alu_a, m_a);
        chk("alu_b", bus.alu_b, m_b);
        chk("v_count", bus.v_count, m_vc);
        if (exp_valid) begin
            chk("rsp_opcode", bus.rsp_opcode, m_op);
            chk("rsp_y", bus.rsp_y, m_a ^ m_b ^ m_op);
            chk("rsp_v", bus.rsp_v, m_op[0]);
            chk("rsp_last", bus.rsp_last, last);
        end
        if (!rst_n) begin
            model_reset();
        end else if (!m_busy) begin
            if (bus.sweep_start) begin
                m_busy = 1; m_drive = 1; m_sweep = 1;
                m_op = 0; m_a = bus.sweep_a; m_b = bus.sweep_b;
                m_vc = 0;
            end else if (bus.cmd_valid) begin
                m_busy = 1; m_drive = 1; m_sweep = 0;
                m_op = bus.cmd_opcode; m_a = bus.cmd_a;
                m_b = bus.cmd_b;
                cmd_taken = 1;
            end
        end else if (m_drive) begin
            if (m_sweep && m_op[0]) m_vc++;
            m_drive = 0;
        end else if (bus.rsp_ready) begin
            if (last) m_busy = 0;
            else begin
                m_op++;
                m_drive = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input bit rnd_ready);
        int n = 0;
        while (m_busy && n < 400) begin
            bus.rsp_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            n++;
        end
        if (m_busy) chk("idle_timeout", 1, 0);
        bus.rsp_ready = 1'b1;
    endtask

    task automatic run_single(input bit [3:0] op, input bit [3:0] a,
                              input bit [3:0] b, input bit rnd_ready);
        int n = 0;
        bus.cmd_opcode = op;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_valid  = 1'b1;
        cmd_taken      = 0;
        while (!cmd_taken && n < 400) begin
            bus.rsp_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            tick();
            n++;
        end
        if (!cmd_taken) chk("accept_timeout", 1, 0);
        bus.cmd_valid = 1'b0;
        wait_idle(rnd_ready);
    endtask

    // bp: stall op 6 for five cycles; stray: pulse sweep_start at op 3;
    // rst9: reset while op 9 is presented.
    task automatic run_sweep(input bit [3:0] a, input bit [3:0] b,
                             input bit bp, input bit stray,
                             input bit rst9, input bit rnd_ready,
                             output int cycles);
        int held = 0;
        cycles = 0;
        bus.sweep_a     = a;
        bus.sweep_b     = b;
        bus.sweep_start = 1'b1;
        bus.rsp_ready   = 1'b1;
        tick();
        bus.sweep_start = 1'b0;
        while (m_busy && cycles < 400) begin
            bus.sweep_start = stray && m_op == 4'd3;
            if (rst9 && m_op == 4'd9 && !m_drive) begin
                bus.rsp_ready = 1'b0;
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                chk("rst_rsp_last", bus.rsp_last, 0);
                chk("rst_rsp_y", bus.rsp_y, 0);
                chk("rst_rsp_opcode", bus.rsp_opcode, 0);
                break;
            end
            if (bp && m_op == 4'd6 && !m_drive && held < 5) begin
                bus.rsp_ready = 1'b0;
                held++;
            end else begin
                bus.rsp_ready = rnd_ready ?
                    ($urandom_range(0, 3) != 0) : 1'b1;
            end
            tick();
            cycles++;
        end
        bus.sweep_start = 1'b0;
        bus.rsp_ready   = 1'b1;
        if (m_busy) chk("sweep_timeout", 1, 0);
    endtask

    initial begin
        int cyc;
        bus.cmd_valid   = 1'b0;
        bus.cmd_opcode  = '0;
        bus.cmd_a       = '0;
        bus.cmd_b       = '0;
        bus.sweep_start = 1'b0;
        bus.sweep_a     = '0;
        bus.sweep_b     = '0;
        bus.rsp_ready   = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_rsp_last", bus.rsp_last, 0);
        chk("reset_rsp_y", bus.rsp_y, 0);
        tick();

        run_single(4'h3, 4'h5, 4'hA, 1'b0);

        run_sweep(4'h5, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, cyc);
        chk("sweep_cycles", cyc, 32);
        tick();
        chk("sweep_v_count", bus.v_count, 8);

        run_sweep(4'h5, 4'hA, 1'b1, 1'b0, 1'b0, 1'b0, cyc);
        chk("bp_cycles", cyc, 37);
        tick();

        bus.cmd_opcode = 4'h7;
        bus.cmd_a      = 4'h2;
        bus.cmd_b      = 4'h9;
        bus.cmd_valid  = 1'b1;
        cmd_taken      = 0;
        run_sweep(4'h3, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, cyc);
        chk("sim_cmd_deferred", cmd_taken, 0);
        tick();
        chk("sim_cmd_taken", cmd_taken, 1);
        bus.cmd_valid = 1'b0;
        wait_idle(1'b0);
        tick();

        run_sweep(4'hE, 4'h1, 1'b0, 1'b0, 1'b1, 1'b0, cyc);
        tick();
        tick();

        run_sweep(4'h6, 4'h6, 1'b0, 1'b1, 1'b0, 1'b0, cyc);
        chk("stray_cycles", cyc, 32);
        tick();
        chk("stray_v_count", bus.v_count, 8);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                run_sweep(4'($urandom), 4'($urandom), 1'b0,
                          1'($urandom), 1'b0, 1'b1, cyc);
            end else begin
                run_single(4'($urandom), 4'($urandom), 4'($urandom),
                           1'b1);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
